lane_distributor_4bits_to_4x8: RTL and testbench
================================================

// Module: lane_distributor_4bits_to_4x8
// PURPOSE
//   Sequential 1-to-8 distributor: accepts a stream of 4-bit nibbles and parks each
//   one in one of 8 lane registers of a 32-bit output bus (lane i = out[4i+3:4i]).
//   Lanes are filled round-robin or by explicit address, and drained per lane by ack.
//   Empty lanes drive all-zero, so an 8-lane OR-merge of the bus yields the live data.
//   This is the fan-out end of the 4x8-lane OR-combine path.
// PARAMETERS
//   LANES  8  number of lanes; power of two, pointer width = log2(LANES)
//   W      4  nibble width per lane
// PORTS
//   clk        in   1          rising-edge clock
//   rst_n      in   1          synchronous reset, active-low
//   in_data    in   W          nibble to distribute
//   in_valid   in   1          in_data valid this cycle
//   in_ready   out  1          target lane can take in_data this cycle
//   mode       in   1          0 = round-robin target, 1 = addressed target
//   in_sel     in   3          target lane when mode = 1
//   out        out  LANES*W    lane registers; lane i = out[W*i+W-1:W*i]
//   out_valid  out  LANES      lane i holds undrained data
//   out_ack    in   LANES      consumer drains lane i
//   busy_cnt   out  4          number of set out_valid bits, 0..8
// BEHAVIOUR
//   Reset (rst_n = 0 at a clk edge):
//   - out = 0, out_valid = 0, busy_cnt = 0, round-robin pointer ptr = 0.
//   - in_ready = 0 while rst_n = 0.
//   Target lane:
//   - tgt = mode ? in_sel : ptr.
//   - Combinational; a mode or in_sel change takes effect the same cycle.
//   in_ready:
//   - Combinational: rst_n & (~out_valid[tgt] | out_ack[tgt]).
//   - in_ready does not depend on in_valid.
//   Write (in_valid & in_ready at edge t):
//   - From t+1: lane tgt holds in_data and out_valid[tgt] = 1.
//   - Latency is 1 cycle; throughput is 1 nibble per cycle while target lanes are free.
//   Drain (out_ack[i] & out_valid[i] at edge t):
//   - From t+1: out_valid[i] = 0 and lane i reads 0.
//   - out_ack on an invalid lane is ignored.
//   - Several lanes may be acked in the same cycle.
//   Same-lane write and ack in one cycle: the write wins; the lane stays valid and holds
//   the new nibble. This gives a zero-bubble refill.
//   Pointer:
//   - Increments by 1 mod LANES on each accepted write with mode = 0 (wraps 7 -> 0).
//   - Unchanged by addressed writes and by acks.
//   - Retained across mode switches.
//   Full case: if all lanes are valid and out_ack[tgt] = 0, in_ready = 0 and no state
//   changes from the input side.
//   Overwrite protection: a valid lane is never overwritten without a same-cycle ack.
//   busy_cnt:
//   - Registered; next = cur + write_accepted - (number of valid lanes acked),
//     where a same-lane write+ack counts net 0.
//   - Always equals popcount(out_valid).
//   Reset mid-operation discards all parked data and any in-flight write.
// TESTING
//   1 Reset, then RR writes 1,2,...,8 on consecutive cycles
//     -> out = 32'h87654321, out_valid = 8'hFF, busy_cnt = 8, in_ready = 0.
//   2 From full, ack lane 0 only
//     -> in_ready = 1 that cycle (ptr wrapped to 0); write 4'hA then
//     -> lane 0 = A, valid, busy_cnt stays 8.
//   3 mode = 1, in_sel = 5, lane 5 empty, write 4'h3
//     -> only out[23:20] = 3; ptr unchanged; a following RR write lands at the old ptr.
//   4 Ack lanes 2 and 6 in the same cycle, plus an ack on an empty lane
//     -> both drained to 0, busy_cnt -= 2, the empty-lane ack has no effect.
//   5 rst_n low for 1 cycle mid-stream with in_valid = 1
//     -> next cycle all outputs 0, ptr = 0, the write is not captured.
//   6 Random stream with random acks for 10k cycles
//     -> scoreboard per lane, busy_cnt == popcount(out_valid), OR of lanes matches the
//        sole valid nibble.

Source files
------------

// File: rtl/lane_distributor_4bits_to_4x8_if.sv
// lane_distributor_4bits_to_4x8_if: nibble input stream and 8-lane output bus of the distributor.
interface lane_distributor_4bits_to_4x8_if #(
    parameter int LANES = 8,
    parameter int W     = 4
);
    logic [W-1:0]               in_data;
    logic                       in_valid;
    logic                       in_ready;
    logic                       mode;
    logic [$clog2(LANES)-1:0]   in_sel;
    logic [LANES*W-1:0]         out;
    logic [LANES-1:0]           out_valid;
    logic [LANES-1:0]           out_ack;
    logic [$clog2(LANES):0]     busy_cnt;

    modport master (
        output in_data, in_valid, mode, in_sel, out_ack,
        input  in_ready, out, out_valid, busy_cnt
    );

    modport slave (
        input  in_data, in_valid, mode, in_sel, out_ack,
        output in_ready, out, out_valid, busy_cnt
    );
endinterface

// File: rtl/lane_distributor_4bits_to_4x8.sv
// lane_distributor_4bits_to_4x8: parks 4-bit nibbles into 8 lane registers, round-robin or addressed,
// drained per lane by ack; empty lanes read zero so the bus can be OR-merged downstream.
module lane_distributor_4bits_to_4x8 #(
    parameter int LANES = 8,
    parameter int W     = 4
) (
    input logic clk,
    input logic rst_n,
    lane_distributor_4bits_to_4x8_if.slave bus
);
    localparam int PW = $clog2(LANES);
    localparam int CW = PW + 1;

    logic [PW-1:0]      ptr_q, ptr_d, tgt;
    logic [LANES*W-1:0] out_q, out_d;
    logic [LANES-1:0]   vld_q, vld_d, drained;
    logic [CW-1:0]      cnt_q, cnt_d, n_drained;
    logic               rdy, wr;

    always_comb begin
        tgt       = bus.mode ? bus.in_sel : ptr_q;
        rdy       = rst_n & (~vld_q[tgt] | bus.out_ack[tgt]);
        wr        = bus.in_valid & rdy;
        drained   = vld_q & bus.out_ack;
        n_drained = '0;
        out_d     = out_q;
        vld_d     = vld_q;
        // a write to a lane acked in the same cycle wins, giving a zero-bubble refill
        for (int i = 0; i < LANES; i++) begin
            n_drained          = n_drained + CW'(drained[i]);
            out_d[W*i +: W]    = (wr && tgt == PW'(i)) ? bus.in_data : (drained[i] ? '0 : out_q[W*i +: W]);
            vld_d[i]           = (wr && tgt == PW'(i)) | (vld_q[i] & ~drained[i]);
        end
        cnt_d = cnt_q + CW'(wr) - n_drained;
        ptr_d = (wr && !bus.mode) ? ptr_q + PW'(1) : ptr_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ptr_q <= '0;
            out_q <= '0;
            vld_q <= '0;
            cnt_q <= '0;
        end else begin
            ptr_q <= ptr_d;
            out_q <= out_d;
            vld_q <= vld_d;
            cnt_q <= cnt_d;
        end
    end

    assign bus.in_ready  = rdy;
    assign bus.out       = out_q;
    assign bus.out_valid = vld_q;
    assign bus.busy_cnt  = cnt_q;
endmodule

// File: tb/tb_lane_distributor_4bits_to_4x8.sv
// tb_lane_distributor_4bits_to_4x8: directed vector table, combinational target checks,
// then a randomized stream compared against a lane-array reference model.
module tb_lane_distributor_4bits_to_4x8;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad   = 0;
    logic rdy_seen;
    logic m_rdy;

    lane_distributor_4bits_to_4x8_if bus();

    lane_distributor_4bits_to_4x8 dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic        rn;
        logic        iv;
        logic [3:0]  d;
        logic        m;
        logic [2:0]  s;
        logic [7:0]  ack;
        logic        rdy;
        logic [31:0] o;
        logic [7:0]  v;
        logic [3:0]  c;
    } vec_t;

    vec_t tv[18];

    logic [3:0] m_lane[8];
    bit         m_vld[8];
    int         m_ptr;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    // reference: lanes as an array, target chosen by rule, drains then write
    task automatic model_step(input logic rn, input logic iv, input logic [3:0] d,
                              input logic m, input logic [2:0] s, input logic [7:0] ack);
        int t;
        t = m ? int'(s) : m_ptr;
        m_rdy = rn && (!m_vld[t] || ack[t]);
        if (!rn) begin
            for (int i = 0; i < 8; i++) begin
                m_lane[i] = 4'h0;
                m_vld[i]  = 0;
            end
            m_ptr = 0;
        end else begin
            for (int i = 0; i < 8; i++)
                if (ack[i]) begin
                    m_lane[i] = 4'h0;
                    m_vld[i]  = 0;
                end
            if (iv && m_rdy) begin
                m_lane[t] = d;
                m_vld[t]  = 1;
                if (!m) m_ptr = (m_ptr + 1) % 8;
            end
        end
    endtask

    task automatic apply(input logic rn, input logic iv, input logic [3:0] d,
                         input logic m, input logic [2:0] s, input logic [7:0] ack);
        rst_n        = rn;
        bus.in_valid = iv;
        bus.in_data  = d;
        bus.mode     = m;
        bus.in_sel   = s;
        bus.out_ack  = ack;
        #1;
        rdy_seen = bus.in_ready;
        model_step(rn, iv, d, m, s, ack);
        @(posedge clk);
        #1;
    endtask

    task automatic model_chk();
        logic [31:0] o;
        logic [7:0]  v;
        int          c;
        c = 0;
        for (int i = 0; i < 8; i++) begin
            o[4*i +: 4] = m_lane[i];
            v[i]        = m_vld[i];
            c += int'(m_vld[i]);
        end
        chk("rand_ready", 32'(rdy_seen), 32'(m_rdy));
        chk("rand_out", bus.out, o);
        chk("rand_valid", 32'(bus.out_valid), 32'(v));
        chk("rand_cnt", 32'(bus.busy_cnt), 32'(c));
    endtask

    initial begin
        logic [7:0] ack;
        logic [3:0] orv;
        // rn iv d m s ack | rdy out valid cnt
        tv[0]  = '{1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 8'h00, 1'b0, 32'h00000000, 8'h00, 4'd0};
        tv[1]  = '{1'b1, 1'b1, 4'h1, 1'b0, 3'd0, 8'h00, 1'b1, 32'h00000001, 8'h01, 4'd1};
        tv[2]  = '{1'b1, 1'b1, 4'h2, 1'b0, 3'd0, 8'h00, 1'b1, 32'h00000021, 8'h03, 4'd2};
        tv[3]  = '{1'b1, 1'b1, 4'h3, 1'b0, 3'd0, 8'h00, 1'b1, 32'h00000321, 8'h07, 4'd3};
        tv[4]  = '{1'b1, 1'b1, 4'h4, 1'b0, 3'd0, 8'h00, 1'b1, 32'h00004321, 8'h0F, 4'd4};
        tv[5]  = '{1'b1, 1'b1, 4'h5, 1'b0, 3'd0, 8'h00, 1'b1, 32'h00054321, 8'h1F, 4'd5};
        tv[6]  = '{1'b1, 1'b1, 4'h6, 1'b0, 3'd0, 8'h00, 1'b1, 32'h00654321, 8'h3F, 4'd6};
        tv[7]  = '{1'b1, 1'b1, 4'h7, 1'b0, 3'd0, 8'h00, 1'b1, 32'h07654321, 8'h7F, 4'd7};
        tv[8]  = '{1'b1, 1'b1, 4'h8, 1'b0, 3'd0, 8'h00, 1'b1, 32'h87654321, 8'hFF, 4'd8};
        tv[9]  = '{1'b1, 1'b1, 4'hF, 1'b0, 3'd0, 8'h00, 1'b0, 32'h87654321, 8'hFF, 4'd8};
        tv[10] = '{1'b1, 1'b1, 4'hA, 1'b0, 3'd0, 8'h01, 1'b1, 32'h8765432A, 8'hFF, 4'd8};
        tv[11] = '{1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 8'h20, 1'b0, 32'h8705432A, 8'hDF, 4'd7};
        tv[12] = '{1'b1, 1'b1, 4'h3, 1'b1, 3'd5, 8'h00, 1'b1, 32'h8735432A, 8'hFF, 4'd8};
        tv[13] = '{1'b1, 1'b1, 4'hC, 1'b0, 3'd0, 8'h02, 1'b1, 32'h873543CA, 8'hFF, 4'd8};
        tv[14] = '{1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 8'h44, 1'b1, 32'h803540CA, 8'hBB, 4'd6};
        tv[15] = '{1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 8'h04, 1'b1, 32'h803540CA, 8'hBB, 4'd6};
        tv[16] = '{1'b0, 1'b1, 4'h9, 1'b0, 3'd0, 8'h00, 1'b0, 32'h00000000, 8'h00, 4'd0};
        tv[17] = '{1'b1, 1'b1, 4'h5, 1'b0, 3'd0, 8'h00, 1'b1, 32'h00000005, 8'h01, 4'd1};

        rst_n        = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data  = '0;
        bus.mode     = 1'b0;
        bus.in_sel   = '0;
        bus.out_ack  = '0;
        m_ptr        = 0;
        for (int i = 0; i < 8; i++) begin
            m_lane[i] = 4'h0;
            m_vld[i]  = 0;
        end
        @(posedge clk);
        #1;

        foreach (tv[i]) begin
            apply(tv[i].rn, tv[i].iv, tv[i].d, tv[i].m, tv[i].s, tv[i].ack);
            chk($sformatf("v%0d_ready", i), 32'(rdy_seen), 32'(tv[i].rdy));
            chk($sformatf("v%0d_out", i), bus.out, tv[i].o);
            chk($sformatf("v%0d_valid", i), 32'(bus.out_valid), 32'(tv[i].v));
            chk($sformatf("v%0d_cnt", i), 32'(bus.busy_cnt), 32'(tv[i].c));
        end

        // lane 0 valid, ptr at 1: target follows mode/in_sel within the cycle
        bus.in_valid = 1'b0;
        bus.mode     = 1'b0;
        #1 chk("comb_rr_ready", 32'(bus.in_ready), 32'd1);
        bus.mode   = 1'b1;
        bus.in_sel = 3'd0;
        #1 chk("comb_sel0_ready", 32'(bus.in_ready), 32'd0);
        bus.out_ack = 8'h01;
        #1 chk("comb_sel0_ack_ready", 32'(bus.in_ready), 32'd1);
        bus.out_ack = 8'h00;
        bus.in_sel  = 3'd3;
        #1 chk("comb_sel3_ready", 32'(bus.in_ready), 32'd1);
        apply(1'b1, 1'b0, 4'h0, 1'b0, 3'd0, 8'h00);
        chk("hold_out", bus.out, 32'h00000005);

        apply(1'b0, 1'b0, 4'h0, 1'b0, 3'd0, 8'h00);
        for (int k = 0; k < 10000; k++) begin
            ack = 8'($urandom) & 8'($urandom) & 8'($urandom);
            apply($urandom_range(0, 499) != 0, $urandom_range(0, 3) != 0, 4'($urandom),
                  $urandom_range(0, 3) == 0, 3'($urandom), ack);
            model_chk();
            chk("rand_popcnt", 32'(bus.busy_cnt), 32'($countones(bus.out_valid)));
            if ($countones(bus.out_valid) == 1) begin
                orv = 4'h0;
                for (int i = 0; i < 8; i++) orv |= bus.out[4*i +: 4];
                for (int i = 0; i < 8; i++)
                    if (m_vld[i]) chk("rand_or_merge", 32'(orv), 32'(m_lane[i]));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
